// File: rtl/instruction_cache_pkg.sv
// Shared types and field widths for the direct-mapped instruction cache.
package instruction_cache_pkg;

   localparam int OFFSET_W = 2;
   localparam int INDEX_W  = 3;
   localparam int TAG_W    = 3;
   localparam int LINE_W   = 128;
   localparam int WORD_W   = 32;
   localparam int CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE,
      MEM_READ,
      UPDATE
   } icache_state_e;

   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFFSET_W-1:0] off);
      return line[off*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one write port for line fills, one combinational read port.
module icache_line_array
   import instruction_cache_pkg::*;
#(
   parameter int BLOCKS = 8,
   parameter int WORDS  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [INDEX_W-1:0]        wr_index,
   input  logic [TAG_W-1:0]          wr_tag,
   input  logic [WORDS*WORD_W-1:0]   wr_data,
   input  logic [INDEX_W-1:0]        rd_index,
   output logic                      rd_valid,
   output logic [TAG_W-1:0]          rd_tag,
   output logic [WORDS*WORD_W-1:0]   rd_data
);

   logic [BLOCKS-1:0]        valid_q, valid_d;
   logic [TAG_W-1:0]         tag_q  [BLOCKS];
   logic [WORDS*WORD_W-1:0]  data_q [BLOCKS];

   always_comb begin
      valid_d = valid_q;
      if (wr_en) valid_d[wr_index] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   // A fill cut short by reset must leave no trace in the arrays.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with a three-state line-fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instruction_cache
   import instruction_cache_pkg::*;
#(
   parameter int BLOCKS = 8,
   parameter int WORDS  = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [31:0]        pc,
   output logic [WORD_W-1:0]  instruction,
   output logic               busywait,
   output logic               mem_read,
   output logic [5:0]         mem_address,
   input  logic [LINE_W-1:0]  mem_readdata,
   input  logic               mem_busywait
`ifdef ICACHE_STATS_EN
   ,
   output logic [CNT_W-1:0]   hit_count,
   output logic [CNT_W-1:0]   miss_count
`endif
);

   icache_state_e        state_q, state_d;
   logic [WORD_W-1:0]    instr_q, instr_d;
   logic [OFFSET_W-1:0]  offset;
   logic [INDEX_W-1:0]   index;
   logic [TAG_W-1:0]     tag;
   logic                 rd_valid;
   logic [TAG_W-1:0]     rd_tag;
   logic [LINE_W-1:0]    rd_data;
   logic                 hit;
   logic                 fill_en;
   logic                 unused_pc;

   assign offset    = pc[3:2];
   assign index     = pc[6:4];
   assign tag       = pc[9:7];
   assign unused_pc = ^{pc[31:10], pc[1:0]};

   icache_line_array #(
      .BLOCKS (BLOCKS),
      .WORDS  (WORDS)
   ) u_lines (
      .clk      (CLK),
      .rst      (RESET),
      .wr_en    (fill_en),
      .wr_index (index),
      .wr_tag   (tag),
      .wr_data  (mem_readdata),
      .rd_index (index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data)
   );

   assign hit = (state_q == IDLE) && rd_valid && (rd_tag == tag);

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      busywait    = 1'b1;
      mem_read    = 1'b0;
      mem_address = '0;
      fill_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit) begin
               busywait = 1'b0;
               instr_d  = line_word(rd_data, offset);
            end else begin
               state_d = MEM_READ;
            end
         end
         MEM_READ: begin
            mem_read    = 1'b1;
            mem_address = pc[9:4];
            if (!mem_busywait) state_d = UPDATE;
         end
         UPDATE: begin
            fill_en = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The hit word appears in the same cycle; otherwise the last hit is held.
   assign instruction = instr_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      if ((state_q == IDLE) && !hit && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule
